// File: rtl/run_ctrl.sv
// Run controller: sequences IDLE -> RUN -> DONE for a small core, producing the
// fetch address, run enable, completion/timeout flags and a RUN-cycle counter.
module run_ctrl #(
    parameter int unsigned PC_W    = 10,
    parameter int unsigned START0  = 0,
    parameter int unsigned START1  = 64,
    parameter int unsigned START2  = 128,
    parameter int unsigned START3  = 192,
    parameter logic [15:0] TIMEOUT = 16'hFFF0
) (
    input  logic            clk,
    input  logic            init_n,
    input  logic [1:0]      prog_sel,
    input  logic            halt,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            stall,
    output logic [PC_W-1:0] pc,
    output logic            run,
    output logic            done,
    output logic            timeout,
    output logic [15:0]     cycle_ct
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            run_q, run_d;
    logic            done_q, done_d;
    logic            timeout_q, timeout_d;
    logic [15:0]     cycle_ct_q, cycle_ct_d;

    logic [PC_W-1:0] start_pc;
    logic            halt_acc;
    logic            tmo_hit;

    always_comb begin
        start_pc = PC_W'(START0);
        case (prog_sel)
            2'd0:    start_pc = PC_W'(START0);
            2'd1:    start_pc = PC_W'(START1);
            2'd2:    start_pc = PC_W'(START2);
            default: start_pc = PC_W'(START3);
        endcase
    end

    // A stalled instruction is not executed, so its halt flag does not count.
    assign halt_acc = halt & ~stall;
    assign tmo_hit  = (cycle_ct_q == TIMEOUT);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        run_d      = run_q;
        done_d     = done_q;
        timeout_d  = timeout_q;
        cycle_ct_d = cycle_ct_q;
        case (state_q)
            IDLE: begin
                pc_d    = start_pc;
                run_d   = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (halt_acc) begin
                    cycle_ct_d = cycle_ct_q + 16'd1;
                    done_d     = 1'b1;
                    run_d      = 1'b0;
                    state_d    = DONE;
                end else if (tmo_hit) begin
                    // Forced completion freezes the counter at the limit.
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    run_d     = 1'b0;
                    state_d   = DONE;
                end else begin
                    cycle_ct_d = cycle_ct_q + 16'd1;
                    if (!stall) begin
                        if (branch_taken) pc_d = branch_target;
                        else              pc_d = pc_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
                run_d   = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            run_q      <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            cycle_ct_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            run_q      <= run_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            cycle_ct_q <= cycle_ct_d;
        end
    end

    assign pc       = pc_q;
    assign run      = run_q;
    assign done     = done_q;
    assign timeout  = timeout_q;
    assign cycle_ct = cycle_ct_q;

endmodule
